// File: rtl/fracturable_logic_element_pkg.sv
// Shared sizing helpers and configuration-word layout for the fracturable
// logic element. Control bits follow the LUT table inside the config word;
// the offsets below are relative to the first bit after the table.
package fracturable_logic_element_pkg;

    localparam int CTRL_BITS   = 7;

    localparam int OFF_FRAC    = 0;
    localparam int OFF_COMB_A  = 1;
    localparam int OFF_CE_A    = 2;
    localparam int OFF_INIT_A  = 3;
    localparam int OFF_COMB_B  = 4;
    localparam int OFF_CE_B    = 5;
    localparam int OFF_INIT_B  = 6;

    // Number of LUT table bits for a w-input LUT.
    function automatic int lut_conf(input int w);
        return 1 << w;
    endfunction

    // Total configuration bits: table plus control bits.
    function automatic int fle_conf(input int w);
        return (1 << w) + CTRL_BITS;
    endfunction

endpackage

// File: rtl/fracturable_logic_element_lut.sv
// Purely combinational fracturable LUT. Unfractured, both outputs read the
// full table at data_in. Fractured, the top input is ignored: output A reads
// the lower half of the table and output B reads the upper half.
module fracturable_lut
    import fracturable_logic_element_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [lut_conf(WIDTH)-1:0] lut_table,
    input  logic                       frac,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       lut_a,
    output logic                       lut_b
);

    logic [WIDTH-1:0] idx_a;
    logic [WIDTH-1:0] idx_b;

    // Select table addresses for each half, then look them up.
    always_comb begin
        idx_a = data_in;
        idx_b = data_in;
        if (frac) begin
            idx_a = {1'b0, data_in[WIDTH-2:0]};
            idx_b = {1'b1, data_in[WIDTH-2:0]};
        end
        lut_a = lut_table[idx_a];
        lut_b = lut_table[idx_b];
    end

endmodule

// File: rtl/fracturable_logic_element.sv
// Fracturable logic element: one WIDTH-input LUT, splittable into two
// (WIDTH-1)-input LUTs, each output with its own optionally-enabled register.
// Configuration shifts LSB-first into a shadow register and is committed to
// the active configuration only after a complete load.
// Optional macro LE_CONFIG_CHAIN_OUT_EN drives config_out from shadow bit 0
// for daisy-chaining; without it config_out is tied low.
//
// Strobe semantics: config_shift moves one bit per cycle it is high.
// config_commit is sampled each cycle; it is accepted only when the load is
// complete and no shift happens in the same cycle, otherwise it sets the
// sticky config_error.
module fracturable_logic_element
    import fracturable_logic_element_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clock_enable,
    output logic             data_out_a,
    output logic             data_out_b,
    input  logic             config_shift,
    input  logic             config_in,
    input  logic             config_commit,
    output logic             config_out,
    output logic             config_complete,
    output logic             config_error
);

    localparam int LUT_BITS  = lut_conf(WIDTH);
    localparam int CONF_BITS = fle_conf(WIDTH);
    localparam int CNT_W     = $clog2(CONF_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONF_BITS);

    logic [CONF_BITS-1:0] shadow_q, shadow_d;
    logic [CONF_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 error_q, error_d;
    logic                 reg_a_q, reg_a_d;
    logic                 reg_b_q, reg_b_d;

    logic complete;
    logic commit_ok;
    logic lut_a, lut_b;

    logic [LUT_BITS-1:0] lut_table;
    logic frac, comb_a, ce_a, comb_b, ce_b;

    assign lut_table = active_q[LUT_BITS-1:0];
    assign frac      = active_q[LUT_BITS + OFF_FRAC];
    assign comb_a    = active_q[LUT_BITS + OFF_COMB_A];
    assign ce_a      = active_q[LUT_BITS + OFF_CE_A];
    assign comb_b    = active_q[LUT_BITS + OFF_COMB_B];
    assign ce_b      = active_q[LUT_BITS + OFF_CE_B];

    assign complete  = (count_q == CNT_FULL);
    assign commit_ok = config_commit & complete & ~config_shift;

    fracturable_lut #(.WIDTH(WIDTH)) u_lut (
        .lut_table (lut_table),
        .frac      (frac),
        .data_in   (data_in),
        .lut_a     (lut_a),
        .lut_b     (lut_b)
    );

    // Config loader: shift with saturating count, atomic commit, sticky error.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        error_d  = error_q;
        if (config_shift) begin
            shadow_d = {config_in, shadow_q[CONF_BITS-1:1]};
            if (!complete) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (commit_ok) begin
            active_d = shadow_q;
            count_d  = '0;
        end else if (config_commit) begin
            error_d = 1'b1;
        end
    end

    // Output registers: commit loads init values, otherwise enabled LUT capture.
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        if (commit_ok) begin
            reg_a_d = shadow_q[LUT_BITS + OFF_INIT_A];
            reg_b_d = shadow_q[LUT_BITS + OFF_INIT_B];
        end else begin
            if (!ce_a || clock_enable) reg_a_d = lut_a;
            if (!ce_b || clock_enable) reg_b_d = lut_b;
        end
    end

    // State update with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            reg_a_q  <= 1'b0;
            reg_b_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            error_q  <= error_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
        end
    end

    assign data_out_a      = comb_a ? lut_a : reg_a_q;
    assign data_out_b      = comb_b ? lut_b : reg_b_q;
    assign config_complete = complete;
    assign config_error    = error_q;

`ifdef LE_CONFIG_CHAIN_OUT_EN
    assign config_out = shadow_q[0];
`else
    assign config_out = 1'b0;
`endif

endmodule

// File: tb/tb_fracturable_logic_element.sv
// Bench for fracturable_logic_element at WIDTH=4 (23 config bits).
// A behavioural model tracks the shifted stream and decoded configuration;
// a negedge process compares every output each cycle, and directed scenarios
// add hand-computed literal expectations.
module tb_fracturable_logic_element;

    localparam int W  = 4;
    localparam int CB = 23;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         clock_enable;
    logic         data_out_a, data_out_b;
    logic         config_shift, config_in, config_commit;
    logic         config_out, config_complete, config_error;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    fracturable_logic_element #(.WIDTH(W)) dut (
        .clock           (clock),
        .reset           (reset),
        .data_in         (data_in),
        .clock_enable    (clock_enable),
        .data_out_a      (data_out_a),
        .data_out_b      (data_out_b),
        .config_shift    (config_shift),
        .config_in       (config_in),
        .config_commit   (config_commit),
        .config_out      (config_out),
        .config_complete (config_complete),
        .config_error    (config_error)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_q[$];      // m_q[i] is shadow bit i
    int        m_shifts;    // shifts since reset/commit (unbounded)
    bit        m_err;
    bit [15:0] m_tab;
    bit        m_frac, m_comb_a, m_ce_a, m_comb_b, m_ce_b;
    bit        m_reg_a, m_reg_b;

    function automatic bit m_lut(input bit is_b);
        int idx;
        if (m_frac) idx = (int'(data_in) % 8) + (is_b ? 8 : 0);
        else        idx = int'(data_in);
        return m_tab[idx];
    endfunction

    function automatic bit exp_a();
        return m_comb_a ? m_lut(1'b0) : m_reg_a;
    endfunction

    function automatic bit exp_b();
        return m_comb_b ? m_lut(1'b1) : m_reg_b;
    endfunction

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < CB; i++) m_q.push_back(1'b0);
        m_shifts = 0; m_err = 0; m_tab = '0;
        m_frac = 0; m_comb_a = 0; m_ce_a = 0; m_comb_b = 0; m_ce_b = 0;
        m_reg_a = 0; m_reg_b = 0;
    endtask

    always @(posedge clock) begin
        bit acc, la, lb;
        if (reset) begin
            m_reset();
        end else begin
            acc = config_commit && (m_shifts >= CB) && !config_shift;
            la  = m_lut(1'b0);
            lb  = m_lut(1'b1);
            if (acc) begin
                for (int i = 0; i < 16; i++) m_tab[i] = m_q[i];
                m_frac   = m_q[16];
                m_comb_a = m_q[17];
                m_ce_a   = m_q[18];
                m_reg_a  = m_q[19];
                m_comb_b = m_q[20];
                m_ce_b   = m_q[21];
                m_reg_b  = m_q[22];
                m_shifts = 0;
            end else begin
                if (config_commit) m_err = 1'b1;
                if (!m_ce_a || clock_enable) m_reg_a = la;
                if (!m_ce_b || clock_enable) m_reg_b = lb;
            end
            if (config_shift) begin
                m_q.push_back(config_in);
                void'(m_q.pop_front());
                m_shifts++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_out_a", data_out_a, exp_a());
            chk("cyc_out_b", data_out_b, exp_b());
            chk("cyc_complete", config_complete, m_shifts >= CB);
            chk("cyc_error", config_error, m_err);
`ifdef LE_CONFIG_CHAIN_OUT_EN
            chk("cyc_cfg_out", config_out, m_q[0]);
`else
            chk("cyc_cfg_out", config_out, 1'b0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [CB-1:0] mk(input logic [15:0] t, input logic fr,
                                         input logic ca, input logic cea, input logic ia,
                                         input logic cb, input logic ceb, input logic ib);
        return {ib, ceb, cb, ia, cea, ca, fr, t};
    endfunction

    task automatic shift_bits(input logic [CB-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            config_shift = 1'b1;
            config_in    = w[i];
            tick();
        end
        config_shift = 1'b0;
        config_in    = 1'b0;
    endtask

    task automatic commit();
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
    endtask

    task automatic load(input logic [CB-1:0] w);
        shift_bits(w, CB);
        commit();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; data_in = '0; clock_enable = 1'b0;
        config_shift = 1'b0; config_in = 1'b0; config_commit = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_out_a", data_out_a, 1'b0);
        chk("rst_out_b", data_out_b, 1'b0);
        chk("rst_complete", config_complete, 1'b0);
        chk("rst_error", config_error, 1'b0);

        // AND4 in unfractured combinational mode on both outputs.
        shift_bits(mk(16'h8000, 0, 1, 0, 0, 1, 0, 0), CB);
        chk("and4_complete", config_complete, 1'b1);
        commit();
        chk("and4_error", config_error, 1'b0);
        chk("and4_complete_clr", config_complete, 1'b0);
        data_in = 4'hF; #1;
        chk("and4_F_a", data_out_a, 1'b1);
        chk("and4_F_b", data_out_b, 1'b1);
        data_in = 4'hE; #1;
        chk("and4_E_a", data_out_a, 1'b0);
        chk("and4_E_b", data_out_b, 1'b0);
        for (int v = 0; v < 16; v++) begin
            data_in = W'(v);
            tick();
        end

        // Registered output, always enabled: init 0 then LUT value.
        data_in = 4'h3;
        load(mk(16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
        chk("reg_first_a", data_out_a, 1'b0);
        chk("reg_first_b", data_out_b, 1'b0);
        tick();
        chk("reg_next_a", data_out_a, 1'b1);
        chk("reg_next_b", data_out_b, 1'b1);

        // Registered output with clock enable on A.
        clock_enable = 1'b0;
        load(mk(16'hFFFF, 0, 0, 1, 0, 0, 0, 0));
        chk("ce_commit_a", data_out_a, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ce_hold_a", data_out_a, 1'b0);
        end
        clock_enable = 1'b1;
        tick();
        chk("ce_load_a", data_out_a, 1'b1);
        clock_enable = 1'b0;

        // Fractured: lower half zero, upper half ones.
        load(mk(16'hFF00, 1, 1, 0, 0, 1, 0, 0));
        for (int v = 0; v < 16; v++) begin
            data_in = W'(v); #1;
            chk("frac_a", data_out_a, 1'b0);
            chk("frac_b", data_out_b, 1'b1);
        end
        tick();
        load(mk(16'hFF00, 0, 1, 0, 0, 1, 0, 0));
        data_in = 4'h8; #1;
        chk("unfrac_8_a", data_out_a, 1'b1);
        chk("unfrac_8_b", data_out_b, 1'b1);
        data_in = 4'h7; #1;
        chk("unfrac_7_a", data_out_a, 1'b0);
        chk("unfrac_7_b", data_out_b, 1'b0);
        data_in = 4'h8;

        // Rejected commits: incomplete load, then commit together with shift.
        shift_bits(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0), CB - 1);
        chk("short_complete", config_complete, 1'b0);
        commit();
        chk("short_error", config_error, 1'b1);
        chk("short_keep_a", data_out_a, 1'b1);
        chk("short_keep_b", data_out_b, 1'b1);
        shift_bits(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0), 1);
        chk("full_complete", config_complete, 1'b1);
        config_shift = 1'b1; config_in = 1'b0; config_commit = 1'b1;
        tick();
        config_shift = 1'b0; config_commit = 1'b0;
        chk("clash_error", config_error, 1'b1);
        chk("clash_complete", config_complete, 1'b1);
        chk("clash_keep_a", data_out_a, 1'b1);
        chk("clash_keep_b", data_out_b, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_error", config_error, 1'b0);
        chk("rst2_complete", config_complete, 1'b0);
        chk("rst2_out_a", data_out_a, 1'b0);
        chk("rst2_out_b", data_out_b, 1'b0);

        // Reset mid-shift discards the partial load and the count.
        shift_bits(23'h7FFFFF, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_complete", config_complete, 1'b0);
        chk("midrst_out_a", data_out_a, 1'b0);
        chk("midrst_out_b", data_out_b, 1'b0);
        shift_bits(23'h000001, CB - 1);
        chk("chain_22_complete", config_complete, 1'b0);
        shift_bits(23'h000000, 1);
        chk("chain_23_complete", config_complete, 1'b1);
`ifdef LE_CONFIG_CHAIN_OUT_EN
        chk("chain_out", config_out, 1'b1);
`else
        chk("chain_out", config_out, 1'b0);
`endif
        tick();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fracturable_logic_element.md
Name: fracturable_logic_element

Overview:
Second-generation configurable logic element for the FPGA fabric. It contains a WIDTH-input LUT that can be split into two (WIDTH-1)-input LUTs, giving outputs A and B, and each output has its own register. The register has a clock enable, an init value and a comb/seq output select. Configuration is loaded serially into a shadow register, checked for a complete load, then committed atomically to the active configuration. Instances sit in the logic-block tile and are daisy-chained on the configuration scan chain.

Parameters:
WIDTH, 6, LUT input count (>=2); fractured halves use data_in[WIDTH-2:0]
CONF_BITS, 2**WIDTH+7, derived localparam (not overridable): total configuration bits

Ports:
clock  input  1  single fabric clock; all state on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  LUT inputs
clock_enable  input  1  register enable; used only when the output's ce_used bit is set
data_out_a  output  1  output A
data_out_b  output  1  output B
config_shift  input  1  shift one config bit per cycle
config_in  input  1  serial config bit
config_commit  input  1  one-cycle pulse: shadow -> active
config_out  output  1  serial chain output
config_complete  output  1  exactly CONF_BITS or more shifts since last commit/reset
config_error  output  1  sticky: rejected commit

Behaviour:
- Config layout, index within CONF_BITS:
  - [2**W-1:0] LUT table
  - [2**W] frac
  - [+1] comb_a, [+2] ce_a, [+3] init_a
  - [+4] comb_b, [+5] ce_b, [+6] init_b
- Reset: shadow=0, active=0, shift count=0, config_complete=0, config_error=0, reg_a=reg_b=0. With active=0, all outputs are 0.
- Shift (config_shift=1):
  - shadow <= {config_in, shadow[CONF_BITS-1:1]}; the stream is LSB-first.
  - Count increments and saturates at CONF_BITS.
  - config_complete = (count==CONF_BITS).
  - Extra shifts keep shifting and the count stays saturated.
- Commit accepted only when config_commit=1, config_complete=1 and config_shift=0. On the accepting edge:
  - active <= shadow
  - reg_a <= shadow init_a; reg_b <= shadow init_b
  - count <= 0; config_complete <= 0
  - The new config is visible the following cycle.
- Commit rejected otherwise (incomplete load, or simultaneous shift):
  - config_error <= 1; active and registers are unchanged.
  - The shift in that cycle still happens.
  - config_error clears only on reset.
- LUT:
  - frac=0: lut_a = lut_b = table[data_in].
  - frac=1: lut_a = table[{0,data_in[W-2:0]}] (lower half); lut_b = table[{1,data_in[W-2:0]}] (upper half). data_in[W-1] is ignored.
- Register x in {a,b}:
  - Loads lut_x on each edge when ce_x=0, or when ce_x=1 and clock_enable=1; otherwise it holds.
  - Reset has priority over commit; commit has priority over the normal update.
- Output x:
  - comb_x=1: data_out_x = lut_x (0 latency, combinational from data_in).
  - comb_x=0: data_out_x = reg_x (1-cycle latency).
- Reset mid-shift discards the partial load; the active config returns to 0.
- Shifting never disturbs the active config or the registers.

Optional Feature:
- Macro: LE_CONFIG_CHAIN_OUT_EN.
- Defined: config_out = shadow[0], so the chain can be daisy-chained. The bit appears one cycle after each shift edge.
- Undefined: config_out tied to 0. The port remains, so instance wiring is unchanged.

Decomposition:
- Shared helpers package/include holds:
  - lut_conf(W)=2**W
  - fle_conf(W)=2**W+7
  - named bit-offset constants for frac, comb_a, ce_a, init_a, comb_b, ce_b, init_b
- Sub-module: fracturable_lut. Purely combinational; inputs table, frac and data_in; outputs lut_a and lut_b.
- The config FSM (count/complete/error) and the output registers stay in the top module.

Test Plan:
All scenarios use WIDTH=4, CONF_BITS=23.
- Table=0x8000, frac=0, comb_a=1; 23 shifts + commit -> config_error=0. Next cycle: data_in=0xF gives data_out_a=1; 0xE gives 0; data_out_b follows data_out_a.
- Table=0xFFFF, comb_a=0, init_a=0, ce_a=0; commit -> data_out_a=0 the cycle after commit, then 1 one cycle later.
- ce_a=1, comb_a=0, table=0xFFFF, init_a=0; clock_enable=0 for 5 cycles -> data_out_a stays 0; clock_enable=1 -> 1 after one edge.
- Table=0xFF00, frac=1, comb_a=comb_b=1; any data_in -> data_out_a=0, data_out_b=1. Set frac=0 and recommit -> data_in=0x8 gives both outputs 1.
- Commit after 22 shifts -> config_error=1, outputs unchanged. Then commit with shift asserted in the same cycle after 23 shifts -> still rejected, error stays 1. Reset -> error=0.
- Reset asserted after 10 shifts -> count=0, config_complete=0, outputs 0. With LE_CONFIG_CHAIN_OUT_EN, shift a 1 followed by 22 zeros -> config_out=1 after the 23rd edge.
